// File: rtl/program_loader_if.sv
// program_loader_if: valid/ready byte stream feeding the program loader.
interface program_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    modport master (output in_valid, output in_data, input in_ready);
    modport slave (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader.sv
// program_loader: writes a framed byte stream (length, bytes, checksum) into instruction memory
// and holds the CPU in reset until a complete frame checks out.
module program_loader #(
    parameter logic [7:0]  BASE_ADDR = 8'h00,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic            clk,
    input  logic            reset,
    program_loader_if.slave src,
    input  logic            restart,
    output logic            mem_we,
    output logic [7:0]      mem_addr,
    output logic [7:0]      mem_wdata,
    output logic            cpu_reset,
    output logic            done,
    output logic            err,
    output logic [1:0]      err_code
);
    typedef enum logic [2:0] {WAIT_LEN, DATA, CSUM, RUN, ERROR} loaderState;
    loaderState  state, nextState;
    logic [7:0]  len, idx, sum, csumTotal;
    logic [31:0] idleCnt;
    logic [1:0]  errCode, nextErrCode;
    logic        loading, inFrame, accept, writeByte, timedOut;
    assign loading     = state inside {WAIT_LEN, DATA, CSUM};
    assign inFrame     = state inside {DATA, CSUM};
    assign src.in_ready = loading;
    assign accept      = src.in_valid && loading;
    assign writeByte   = accept && state == DATA;
    assign csumTotal   = sum + src.in_data;
    // The counter holds the idle cycles already seen, so this idle cycle is the TIMEOUT-th one.
    assign timedOut    = TIMEOUT != 0 && inFrame && !accept && idleCnt == TIMEOUT - 1;
    always_comb begin
        nextState = state;
        case (state)
            WAIT_LEN: if (accept) nextState = src.in_data == 8'd0 ? ERROR : DATA;
            DATA:     if (accept) nextState = idx == len - 8'd1 ? CSUM : DATA;
                      else if (timedOut) nextState = ERROR;
            CSUM:     if (accept) nextState = csumTotal == 8'd0 ? RUN : ERROR;
                      else if (timedOut) nextState = ERROR;
            RUN:      if (restart) nextState = WAIT_LEN;
            ERROR:    if (restart) nextState = WAIT_LEN;
            default:  nextState = WAIT_LEN;
        endcase
        nextErrCode = nextState != ERROR ? 2'b00 :
                      state == ERROR     ? errCode :
                      timedOut           ? 2'b10 :
                      state == WAIT_LEN  ? 2'b11 : 2'b01;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_LEN;
            errCode   <= 2'b00;
            len       <= 8'd0;
            idx       <= 8'd0;
            sum       <= 8'd0;
            idleCnt   <= 32'd0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 8'd0;
        end else begin
            state   <= nextState;
            errCode <= nextErrCode;
            mem_we  <= writeByte;
            idleCnt <= (accept || !inFrame) ? 32'd0 : idleCnt + 32'd1;
            if (state == WAIT_LEN && accept) len <= src.in_data;
            if (writeByte) begin
                mem_addr  <= BASE_ADDR + idx;
                mem_wdata <= src.in_data;
                idx       <= idx + 8'd1;
                sum       <= sum + src.in_data;
            end else if (!inFrame) begin
                idx <= 8'd0;
                sum <= 8'd0;
            end
        end
    end
    assign cpu_reset = state != RUN;
    assign done      = state == RUN;
    assign err       = state == ERROR;
    assign err_code  = errCode;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: drives two loaders (base 00/timeout 8 and base FE/timeout off) in lockstep
// and checks them against frame-level expectations derived from length, bytes and checksum.
module tb_program_loader;
    logic       clk = 0, reset = 1, restart = 0, valid = 0;
    logic [7:0] data = 0;
    int         checks = 0, passes = 0, fails = 0;
    logic       mw0, mw1, cr0, cr1, dn0, dn1, er0, er1;
    logic [7:0] ma0, ma1, wd0, wd1;
    logic [1:0] ec0, ec1;
    logic [7:0] fr[$];
    program_loader_if bus0 ();
    program_loader_if bus1 ();
    assign bus0.in_valid = valid;
    assign bus0.in_data  = data;
    assign bus1.in_valid = valid;
    assign bus1.in_data  = data;
    program_loader #(.BASE_ADDR(8'h00), .TIMEOUT(8)) u0 (
        .clk(clk), .reset(reset), .src(bus0), .restart(restart), .mem_we(mw0), .mem_addr(ma0),
        .mem_wdata(wd0), .cpu_reset(cr0), .done(dn0), .err(er0), .err_code(ec0));
    program_loader #(.BASE_ADDR(8'hFE), .TIMEOUT(0)) u1 (
        .clk(clk), .reset(reset), .src(bus1), .restart(restart), .mem_we(mw1), .mem_addr(ma1),
        .mem_wdata(wd1), .cpu_reset(cr1), .done(dn1), .err(er1), .err_code(ec1));
    always #5 clk = ~clk;
    // Status word: {in_ready, mem_we, cpu_reset, done, err, err_code}
    localparam logic [6:0] IDLE = 7'b1010000, RUNNING = 7'b0001000;
    localparam logic [6:0] E_CSUM = 7'b0010101, E_TIME = 7'b0010110, E_ZERO = 7'b0010111;
    function automatic logic [6:0] st(input int i);
        return i == 0 ? {bus0.in_ready, mw0, cr0, dn0, er0, ec0} : {bus1.in_ready, mw1, cr1, dn1, er1, ec1};
    endfunction
    function automatic logic [15:0] wr(input int i);
        return i == 0 ? {ma0, wd0} : {ma1, wd1};
    endfunction
    function automatic logic [7:0] base(input int i);
        return i == 0 ? 8'h00 : 8'hFE;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step(input int k, input logic [7:0] wd);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("frame_status%0d", i), 32'(st(i)), 32'({1'b1, k >= 0, 1'b1, 4'b0000}));
            if (k >= 0) chk($sformatf("write%0d_k%0d", i, k), 32'(wr(i)), 32'({base(i) + 8'(k), wd}));
        end
        @(posedge clk); #1;
    endtask
    task automatic sendFrame(input logic [7:0] f[$], input int maxGap);
        int len = int'(f[0]);
        int k = -1;
        logic [7:0] wd = 0, sum = 0;
        for (int p = 0; p < f.size(); p++) begin
            if (maxGap > 0) repeat ($urandom_range(maxGap, 0)) begin
                valid = 0;
                data = 8'($urandom);
                step(k, wd);
                k = -1;
            end
            valid = 1;
            data = f[p];
            step(k, wd);
            k = (p >= 1 && p <= len) ? p - 1 : -1;
            wd = f[p];
            if (p >= 1) sum += f[p];
        end
        valid = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk($sformatf("frame_end%0d_len%0d", i, len), 32'(st(i)),
                32'(len == 0 ? E_ZERO : sum == 8'd0 ? RUNNING : E_CSUM));
        @(posedge clk); #1;
    endtask
    task automatic restartPulse();
        restart = 1;
        @(posedge clk); #1;
        restart = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk($sformatf("restart%0d", i), 32'(st(i)), 32'(IDLE));
        @(posedge clk); #1;
    endtask
    task automatic doReset();
        reset = 1;
        valid = 0;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_status%0d", i), 32'(st(i)), 32'(IDLE));
            chk($sformatf("reset_mem%0d", i), 32'(wr(i)), 32'({base(i), 8'h00}));
        end
        @(posedge clk); #1;
    endtask
    initial begin
        doReset();
        fr = {8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hCA};
        sendFrame(fr, 0);
        restartPulse();
        fr = {8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hCB};
        sendFrame(fr, 0);
        restartPulse();
        fr = {8'h00};
        sendFrame(fr, 0);
        restartPulse();
        fr = {8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
        sendFrame(fr, 0);
        restartPulse();
        sendFrame(fr, 3);
        restartPulse();
        // Stall inside a frame: only the TIMEOUT=8 loader gives up.
        valid = 1;
        data = 8'h02;
        @(posedge clk); #1;
        data = 8'h11;
        @(posedge clk); #1;
        valid = 0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("timeout_pre", 32'(st(0)), 32'(IDLE));
        @(negedge clk);
        chk("timeout_err", 32'(st(0)), 32'(E_TIME));
        chk("timeout_off", 32'(st(1)), 32'(IDLE));
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("timeout_off_long", 32'(st(1)), 32'(IDLE));
        @(posedge clk); #1;
        // Restart clears the errored loader while the other, still in DATA, ignores it.
        restartPulse();
        valid = 1;
        data = 8'hCD;
        @(posedge clk); #1;
        data = 8'h22;
        @(negedge clk);
        chk("resume_write1", 32'(wr(1)), 32'({8'hFF, 8'hCD}));
        chk("resume_stat1", 32'(st(1)), 32'(7'b1110000));
        chk("relen_stat0", 32'(st(0)), 32'(IDLE));
        @(posedge clk); #1;
        valid = 0;
        @(negedge clk);
        chk("resume_run1", 32'(st(1)), 32'(RUNNING));
        chk("relen_write0", 32'(wr(0)), 32'({8'h00, 8'h22}));
        chk("relen_we0", 32'(st(0)), 32'(7'b1110000));
        @(posedge clk); #1;
        doReset();
        // Reset mid-frame, with a byte offered on the reset edge itself.
        valid = 1;
        data = 8'h05;
        @(posedge clk); #1;
        data = 8'hAA;
        @(posedge clk); #1;
        data = 8'hBB;
        @(posedge clk); #1;
        reset = 1;
        data = 8'hCC;
        @(negedge clk);
        chk("midreset_write0", 32'(wr(0)), 32'({8'h01, 8'hBB}));
        chk("midreset_write1", 32'(wr(1)), 32'({8'hFF, 8'hBB}));
        @(posedge clk); #1;
        reset = 0;
        valid = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("midreset_status%0d", i), 32'(st(i)), 32'(IDLE));
            chk($sformatf("midreset_mem%0d", i), 32'(wr(i)), 32'({base(i), 8'h00}));
        end
        @(posedge clk); #1;
        fr = {8'h02, 8'h10, 8'h20, 8'hD0};
        sendFrame(fr, 2);
        restartPulse();
        for (int n = 0; n < 6; n++) begin
            logic [7:0] s = 0, b, len;
            len = 8'($urandom_range(40, 1));
            fr = {len};
            for (int j = 0; j < int'(len); j++) begin
                b = 8'($urandom);
                fr.push_back(b);
                s += b;
            end
            fr.push_back(8'(-s) + ($urandom_range(2, 0) == 0 ? 8'd1 : 8'd0));
            sendFrame(fr, 3);
            restartPulse();
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
